// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel scanner: FSM encoding, frame geometry
// defaults and RGB565 field layout.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned H_PIX_DEF  = 128;
    localparam int unsigned V_PIX_DEF  = 128;
    localparam int unsigned ADDR_W_DEF = 7;

    // RGB565 word layout: {R5, G6, B5}
    localparam int unsigned RGB_W = 16;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned R_W   = 5;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned G_W   = 6;
    localparam int unsigned B_LSB = 0;
    localparam int unsigned B_W   = 5;

endpackage

// File: rtl/rgb444_to_565.sv
// Combinational RGB444 -> RGB565 expander using MSB replication.
module rgb444_to_565
    import lcd_pkg::*;
(
    input  logic [3:0]       i_r4,
    input  logic [3:0]       i_g4,
    input  logic [3:0]       i_b4,
    output logic [RGB_W-1:0] o_rgb565_c
);

    // Replicate MSBs into the extra LSBs so 0 and full-scale map exactly.
    always_comb begin
        o_rgb565_c                 = '0;
        o_rgb565_c[R_LSB +: R_W]   = {i_r4, i_r4[3]};
        o_rgb565_c[G_LSB +: G_W]   = {i_g4, i_g4[3:2]};
        o_rgb565_c[B_LSB +: B_W]   = {i_b4, i_b4[3]};
    end

endmodule

// File: rtl/lcd_pixel_scanner.sv
// Raster scanner: reads the frame buffer pixel by pixel (1-cycle read latency),
// expands RGB444 to RGB565 and streams it out on a valid/ready interface.
// Optional colour-bar test pattern: define LCD_SCANNER_TESTPAT_EN.
module lcd_pixel_scanner
    import lcd_pkg::*;
#(
    parameter int unsigned H_PIX  = H_PIX_DEF,
    parameter int unsigned V_PIX  = V_PIX_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
)
(
    input  logic              clk,
    input  logic              reset_n,
`ifdef LCD_SCANNER_TESTPAT_EN
    input  logic              test_mode,
`endif
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              oe,
    input  logic [4:0]        r_in,
    input  logic [4:0]        g_in,
    input  logic [5:0]        b_in,
    output logic [RGB_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(H_PIX - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(V_PIX - 1);

    state_t             r_state;
    logic               r_busy;
    logic               r_frame_done;
    logic [ADDR_W-1:0]  r_row;
    logic [ADDR_W-1:0]  r_col;
    logic               r_oe;
    logic [RGB_W-1:0]   r_pix_data;
    logic               r_pix_valid;
    logic               r_pix_sof;
    logic               r_pix_eol;

    logic [3:0]         w_r4;
    logic [3:0]         w_g4;
    logic [3:0]         w_b4;
    logic [RGB_W-1:0]   w_rgb565;
    logic               w_unused_bits;

    // Upper buffer bits carry no colour information.
    assign w_unused_bits = ^{r_in[4], g_in[4], b_in[5:4]};

`ifdef LCD_SCANNER_TESTPAT_EN
    // Colour-bar source: col MSBs select the bar, each channel all-on or all-off.
    always_comb begin
        w_r4 = r_in[3:0];
        w_g4 = g_in[3:0];
        w_b4 = b_in[3:0];
        if (test_mode) begin
            w_r4 = {4{r_col[ADDR_W-1]}};
            w_g4 = {4{r_col[ADDR_W-2]}};
            w_b4 = {4{r_col[ADDR_W-3]}};
        end
    end
`else
    // Buffer data feeds the expander directly.
    always_comb begin
        w_r4 = r_in[3:0];
        w_g4 = g_in[3:0];
        w_b4 = b_in[3:0];
    end
`endif

    rgb444_to_565 u_expand (
        .i_r4       (w_r4),
        .i_g4       (w_g4),
        .i_b4       (w_b4),
        .o_rgb565_c (w_rgb565)
    );

    // Scan FSM: READ pulses oe, LATCH captures buffer data, SEND waits for the handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_oe         <= 1'b0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_oe        <= 1'b0;
                    r_pix_valid <= 1'b0;
                    if (start) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_oe    <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_oe    <= 1'b0;
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_pix_data  <= w_rgb565;
                    r_pix_valid <= 1'b1;
                    r_pix_sof   <= (r_row == '0) && (r_col == '0);
                    r_pix_eol   <= (r_col == COL_LAST);
                    r_state     <= SEND;
                end
                SEND: begin
                    if (r_pix_valid && pix_ready) begin
                        r_pix_valid <= 1'b0;
                        r_pix_sof   <= 1'b0;
                        r_pix_eol   <= 1'b0;
                        if (r_col != COL_LAST) begin
                            r_col   <= r_col + ADDR_W'(1);
                            r_oe    <= 1'b1;
                            r_state <= READ;
                        end else if (r_row != ROW_LAST) begin
                            r_col   <= '0;
                            r_row   <= r_row + ADDR_W'(1);
                            r_oe    <= 1'b1;
                            r_state <= READ;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_row   <= '0;
                    r_col   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign row        = r_row;
    assign col        = r_col;
    assign oe         = r_oe;
    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;
    assign pix_sof    = r_pix_sof;
    assign pix_eol    = r_pix_eol;

endmodule

// File: tb/tb_lcd_pixel_scanner.sv
// Bench for lcd_pixel_scanner: buffer model with 1-cycle read latency,
// table of single-pixel colour vectors plus multi-cycle sequences.
module tb_lcd_pixel_scanner;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [6:0]  row;
    logic [6:0]  col;
    logic        oe;
    logic [4:0]  r_in;
    logic [4:0]  g_in;
    logic [5:0]  b_in;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;

    int checks = 0;
    int errors = 0;

    logic        use_fixed;
    logic [4:0]  fx_r;
    logic [4:0]  fx_g;
    logic [5:0]  fx_b;

    logic [35:0] outs;
    assign outs = {busy, frame_done, oe, pix_valid, pix_sof, pix_eol, row, col, pix_data};

    lcd_pixel_scanner dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef LCD_SCANNER_TESTPAT_EN
        .test_mode  (1'b0),
`endif
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .row        (row),
        .col        (col),
        .oe         (oe),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffer model: registers its outputs on the posedge where oe=1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in <= '0;
            g_in <= '0;
            b_in <= '0;
        end else if (oe) begin
            if (use_fixed) begin
                r_in <= fx_r;
                g_in <= fx_g;
                b_in <= fx_b;
            end else begin
                r_in <= {row[0], col[3:0]};
                g_in <= {col[0], row[3:0]};
                b_in <= {2'b10, col[6:3] ^ row[6:3]};
            end
        end
    end

    typedef struct {
        logic [4:0]  r;
        logic [4:0]  g;
        logic [5:0]  b;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent arithmetic form of the 4->5/6 bit expansion.
    function automatic logic [15:0] exp565(input int r, input int g, input int b);
        int v;
        v = (r * 2 + r / 8) * 2048 + (g * 4 + g / 4) * 32 + (b * 2 + b / 8);
        return 16'(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int idle_err, oe_seen, stall_err, cyc;
        int k, hs_sof, hs_eol, eol_err, data_err, addr_err, busy_err, fd, fd_busy;
        int er, ec;
        bit fin, sb_done, sb_pending;
        logic [19:0] snap;

        vecs[0] = '{5'h0F, 5'h08, 6'h01, 16'hFC42};
        vecs[1] = '{5'h00, 5'h00, 6'h00, 16'h0000};
        vecs[2] = '{5'h1F, 5'h1F, 6'h3F, 16'hFFFF};
        vecs[3] = '{5'h10, 5'h10, 6'h30, 16'h0000};
        vecs[4] = '{5'h08, 5'h04, 6'h02, 16'h8A24};
        vecs[5] = '{5'h07, 5'h0B, 6'h0C, 16'h75D9};
        vecs[6] = '{5'h03, 5'h0F, 6'h07, 16'h37EE};

        reset_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
        use_fixed = 1'b1; fx_r = '0; fx_g = '0; fx_b = '0;
        #1;
        chk("reset_outs", 64'(outs), 64'd0);

        // Reset then idle for 20 cycles.
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        idle_err = 0; oe_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outs != '0) idle_err++;
            if (oe) oe_seen++;
        end
        chk("idle_outs_nonzero", 64'(idle_err), 64'd0);
        chk("idle_oe_seen", 64'(oe_seen), 64'd0);

        // Single-pixel timing and backpressure.
        do_reset();
        fx_r = vecs[0].r; fx_g = vecs[0].g; fx_b = vecs[0].b;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("c2_oe", 64'(oe), 64'd1);
        chk("c2_busy", 64'(busy), 64'd1);
        chk("c2_addr", 64'({row, col}), 64'd0);
        @(negedge clk);
        chk("c3_oe_valid", 64'({oe, pix_valid}), 64'd0);
        @(negedge clk);
        chk("c4_valid", 64'(pix_valid), 64'd1);
        chk("c4_data", 64'(pix_data), 64'(vecs[0].exp_data));
        chk("c4_sof_eol", 64'({pix_sof, pix_eol}), 64'b10);
        snap = {pix_valid, pix_data, pix_sof, pix_eol, oe};
        stall_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({pix_valid, pix_data, pix_sof, pix_eol, oe} != snap) stall_err++;
        end
        chk("stall_stable", 64'(stall_err), 64'd0);
        pix_ready = 1'b1;
        @(negedge clk);
        chk("release_valid_low", 64'(pix_valid), 64'd0);
        chk("release_oe_col1", 64'({oe, row, col}), 64'({1'b1, 7'd0, 7'd1}));
        @(negedge clk);
        @(negedge clk);
        chk("pix1_sof_eol", 64'({pix_valid, pix_sof, pix_eol}), 64'b100);

        // Table of single-pixel colour vectors.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            fx_r = vecs[i].r; fx_g = vecs[i].g; fx_b = vecs[i].b;
            pix_ready = 1'b1;
            pulse_start();
            cyc = 0;
            while (!pix_valid && cyc < 8) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("vec%0d_data", i), 64'(pix_data), 64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_sof", i), 64'({pix_valid, pix_sof}), 64'b11);
        end

        // Full frame, random pix_ready, start while busy and at frame_done.
        do_reset();
        use_fixed = 1'b0;
        pulse_start();
        k = 0; hs_sof = 0; hs_eol = 0; eol_err = 0; data_err = 0; addr_err = 0;
        busy_err = 0; fd = 0; fd_busy = 0; cyc = 0;
        fin = 0; sb_done = 0; sb_pending = 0;
        while (!fin && cyc < 80000) begin
            er = k / 128; ec = k % 128;
            if (frame_done) begin
                fd++;
                if (busy) fd_busy++;
                fin = 1;
                start = 1'b1;
            end else if (!busy) begin
                busy_err++;
            end
            if (oe && (row != 7'(er) || col != 7'(ec))) addr_err++;
            if (!sb_done && oe && row == 7'd3 && col == 7'd10) begin
                start = 1'b1;
                sb_done = 1;
                sb_pending = 1;
            end
            pix_ready = 1'($urandom_range(0, 1));
            if (pix_valid && pix_ready) begin
                if (pix_data != exp565(ec % 16, er % 16, (ec / 8) ^ (er / 8))) data_err++;
                if (row != 7'(er) || col != 7'(ec)) addr_err++;
                if (pix_sof) hs_sof++;
                if (pix_eol) hs_eol++;
                if (pix_eol != (ec == 127)) eol_err++;
                if (pix_sof != (k == 0)) eol_err++;
                k++;
            end
            @(negedge clk);
            cyc++;
            if (fin) start = 1'b0;
            if (sb_pending) begin
                start = 1'b0;
                sb_pending = 0;
                chk("busy_start_addr", 64'({row, col}), 64'({7'd3, 7'd10}));
                chk("busy_start_busy", 64'(busy), 64'd1);
            end
        end
        chk("frame_timeout", 64'(fin), 64'd1);
        chk("frame_handshakes", 64'(k), 64'd16384);
        chk("frame_sof_count", 64'(hs_sof), 64'd1);
        chk("frame_eol_count", 64'(hs_eol), 64'd128);
        chk("frame_flag_err", 64'(eol_err), 64'd0);
        chk("frame_data_err", 64'(data_err), 64'd0);
        chk("frame_addr_err", 64'(addr_err), 64'd0);
        chk("frame_busy_err", 64'(busy_err), 64'd0);
        chk("frame_busy_at_done", 64'(fd_busy), 64'd0);
        pix_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_done) fd++;
            if (busy || oe) busy_err++;
        end
        chk("frame_done_count", 64'(fd), 64'd1);
        chk("start_at_done_ignored", 64'(busy_err), 64'd0);
        chk("idle_addr_zero", 64'({row, col}), 64'd0);

        // Reset mid-frame at row 64, then restart from (0,0).
        do_reset();
        pix_ready = 1'b1;
        pulse_start();
        cyc = 0; fd = 0;
        while (row != 7'd64 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (frame_done) fd++;
        end
        chk("mid_reach_row64", 64'(row), 64'd64);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outs", 64'(outs), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_no_frame_done", 64'(fd), 64'd0);
        pulse_start();
        chk("restart_addr", 64'({oe, row, col}), 64'({1'b1, 14'd0}));
        cyc = 0;
        while (!pix_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("restart_valid_sof", 64'({pix_valid, pix_sof}), 64'b11);
        chk("restart_pixel_addr", 64'({row, col}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
